// File: rtl/btn_debounce_pulse.sv
// Four independent button channels: 2-flop synchronizer, confirm/hold debounce FSM,
// registered press strobe and debounced level per channel.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_level,
  output logic       btn_any
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM_PRESS,
    ST_PRESSED,
    ST_CONFIRM_RELEASE
  } state_e;

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pulse_q, pulse_d;
      logic             level_q, level_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            if (sync_q[gi]) begin
              state_d = ST_CONFIRM_PRESS;
              cnt_d   = '0;
            end
          end
          ST_CONFIRM_PRESS: begin
            if (!sync_q[gi]) begin
              state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_PRESSED;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (!sync_q[gi]) begin
              state_d = ST_CONFIRM_RELEASE;
              cnt_d   = '0;
            end
          end
          ST_CONFIRM_RELEASE: begin
            if (sync_q[gi]) begin
              state_d = ST_PRESSED;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
        // Level follows the state being entered so it rises with the strobe.
        level_d = (state_d == ST_PRESSED) || (state_d == ST_CONFIRM_RELEASE);
      end

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
          level_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          pulse_q <= pulse_d;
          level_q <= level_d;
        end
      end

      assign btn_pulse[gi] = pulse_q;
      assign btn_level[gi] = level_q;
    end
  endgenerate

  assign btn_any = |btn_pulse;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4: stimulus queues expected
// pulse and level-change events; a forked monitor pops and compares them as they appear.
module tb_btn_debounce_pulse;

  logic       clk;
  logic       clr;
  logic [3:0] btn_raw;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic       btn_any;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t pulse_exp[$];
  exp_t level_exp[$];

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level),
    .btn_any   (btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_pulse(input int cyc, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    pulse_exp.push_back(e);
  endtask

  task automatic push_level(input int cyc, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    level_exp.push_back(e);
  endtask

  task automatic sb_monitor();
    logic [3:0] prev_level;
    exp_t       e;
    prev_level = 4'b0000;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_level = btn_level;
      end else begin
        if (btn_pulse != 4'b0000 || btn_any) begin
          if (pulse_exp.size() == 0) begin
            chk("pulse_unexpected", int'({btn_any, btn_pulse}), 0);
          end else begin
            e = pulse_exp.pop_front();
            chk("pulse_cycle", edge_n, e.cyc);
            chk("pulse_value", int'(btn_pulse), int'(e.val));
            chk("pulse_any", int'(btn_any), 1);
            $display("pulse   edge=%0d btn_pulse=%b btn_any=%b expected edge=%0d value=%b",
                     edge_n, btn_pulse, btn_any, e.cyc, e.val);
          end
        end
        if (btn_level != prev_level) begin
          if (level_exp.size() == 0) begin
            chk("level_unexpected", int'(btn_level), int'(prev_level));
          end else begin
            e = level_exp.pop_front();
            chk("level_cycle", edge_n, e.cyc);
            chk("level_value", int'(btn_level), int'(e.val));
            $display("level   edge=%0d btn_level=%b expected edge=%0d value=%b",
                     edge_n, btn_level, e.cyc, e.val);
          end
          prev_level = btn_level;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] bounce_pat;
    clr     = 1'b1;
    btn_raw = 4'b0000;
    fork
      sb_monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_pulse", int'(btn_pulse), 0);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_any", int'(btn_any), 0);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // Single press held long, then clean release.
    btn_raw = 4'b0100;
    push_pulse(edge_n + 7, 4'b0100);
    push_level(edge_n + 7, 4'b0100);
    repeat (20) @(negedge clk);
    chk("hold_level", int'(btn_level), 4);
    btn_raw = 4'b0000;
    push_level(edge_n + 7, 4'b0000);
    repeat (12) @(negedge clk);

    // Bouncing channel 3 never accepted.
    bounce_pat = 8'b0111_0111;
    for (int i = 7; i >= 0; i--) begin
      btn_raw[3] = bounce_pat[i];
      @(negedge clk);
    end
    btn_raw = 4'b0000;
    repeat (10) @(negedge clk);
    chk("bounce_level", int'(btn_level), 0);

    // Channel 1 held 20 cycles, released with one rebound two cycles later.
    btn_raw = 4'b0010;
    push_pulse(edge_n + 7, 4'b0010);
    push_level(edge_n + 7, 4'b0010);
    repeat (20) @(negedge clk);
    btn_raw = 4'b0000;
    repeat (2) @(negedge clk);
    btn_raw = 4'b0010;
    @(negedge clk);
    btn_raw = 4'b0000;
    push_level(edge_n + 7, 4'b0000);
    repeat (3) @(negedge clk);
    chk("rebound_level_held", int'(btn_level), 2);
    repeat (12) @(negedge clk);

    // Two channels pressed together.
    btn_raw = 4'b1010;
    push_pulse(edge_n + 7, 4'b1010);
    push_level(edge_n + 7, 4'b1010);
    repeat (12) @(negedge clk);
    btn_raw = 4'b0000;
    push_level(edge_n + 7, 4'b0000);
    repeat (12) @(negedge clk);

    // Channel 0 pressed, then clr while channel 2 is confirming.
    btn_raw = 4'b0001;
    push_pulse(edge_n + 7, 4'b0001);
    push_level(edge_n + 7, 4'b0001);
    repeat (10) @(negedge clk);
    btn_raw = 4'b0101;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    clr     = 1'b1;
    btn_raw = 4'b0100;
    #1;
    chk("clr_pulse", int'(btn_pulse), 0);
    chk("clr_level", int'(btn_level), 0);
    chk("clr_any", int'(btn_any), 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    push_pulse(edge_n + 7, 4'b0100);
    push_level(edge_n + 7, 4'b0100);
    repeat (12) @(negedge clk);
    btn_raw = 4'b0000;
    push_level(edge_n + 7, 4'b0000);
    repeat (12) @(negedge clk);

    chk("pulse_queue_drained", pulse_exp.size(), 0);
    chk("level_queue_drained", level_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1250000, stable-sample count required to accept a level change (10 ms at 125 MHz); legal range >= 2.
REQ-002 Port: clk  input  1  system clock, 125 MHz, all state on rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-high.
REQ-004 Port: btn_raw  input  4  raw board buttons BTN3..BTN0, asynchronous to clk, bouncing.
REQ-005 Port: btn_pulse  output  4  per-button single-cycle strobe on accepted press.
REQ-006 Port: btn_level  output  4  per-button debounced level, 1 while accepted pressed.
REQ-007 Port: btn_any  output  1  OR of btn_pulse, same cycle.

Function
REQ-008 Each of the 4 channels SHALL be independent and identical; there is no cross-channel priority or lockout.
REQ-009 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) feeds the channel logic.
REQ-010 Each channel SHALL hold a counter of width ceil(log2(DEBOUNCE_CYCLES)) and a 4-state FSM: IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-011 IDLE: sync=1 -> CONFIRM_PRESS with counter=0; else stay.
REQ-012 CONFIRM_PRESS: sync=0 -> IDLE (bounce rejected, no output); sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-013 PRESSED: sync=0 -> CONFIRM_RELEASE with counter=0; else stay.
REQ-014 CONFIRM_RELEASE: sync=1 -> PRESSED (no output change); sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-015 btn_pulse[i] SHALL be registered, high for exactly the one cycle following the CONFIRM_PRESS->PRESSED transition edge; never on release.
REQ-016 btn_level[i] SHALL be registered, 1 in PRESSED and CONFIRM_RELEASE, 0 in IDLE and CONFIRM_PRESS.
REQ-017 Latency: btn_raw[i] stable 1 from before clock edge 1 -> btn_pulse[i] and btn_level[i] rise at edge DEBOUNCE_CYCLES+3; release latency to btn_level[i] fall SHALL be also DEBOUNCE_CYCLES+3 edges.
REQ-018 A press shorter than DEBOUNCE_CYCLES consecutive sync=1 samples SHALL produce no pulse and no level change.
REQ-019 Holding a button indefinitely SHALL produce exactly one pulse; the next pulse requires an accepted release followed by an accepted press.
REQ-020 Simultaneous presses on several channels SHALL yield simultaneous pulses on all of them; btn_any is a single 1-cycle strobe in that case.
REQ-021 Counters SHALL never wrap; the FSM leaves the confirm state at DEBOUNCE_CYCLES-1.

Reset
REQ-022 clr=1 SHALL immediately force synchronizer flops, counters, btn_pulse, btn_level, btn_any to 0 and all FSMs to IDLE, independent of clk.
REQ-023 Reset asserted mid-confirm or mid-pulse SHALL discard the event with no pulse emitted.
REQ-024 A button held through clr deassertion SHALL be treated as a new press: pulse at DEBOUNCE_CYCLES+3 edges after the first edge with clr=0.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 btn_raw=4'b0100 held from before edge 1 -> btn_pulse=4'b0100 and btn_any=1 for exactly the one cycle following edge 7, btn_level[2]=1 from edge 7, no further pulse while held.
REQ-026 btn_raw[3] toggled 1,1,1,0,1,1,1,0 per cycle -> btn_pulse[3] and btn_level[3] stay 0 throughout.
REQ-027 btn_raw[1] held 20 cycles then released with one 1-cycle rebound 2 cycles after release -> single pulse; btn_level[1] falls DEBOUNCE_CYCLES+3 edges after the last raw 1; no second pulse.
REQ-028 btn_raw=4'b1010 rising at the same edge -> btn_pulse=4'b1010 in one cycle, btn_any=1 for one cycle.
REQ-029 clr pulsed while channel 2 in CONFIRM_PRESS -> all outputs 0 immediately, no pulse; button still held after clr falls -> pulse 7 edges after first edge with clr=0.
